// File: rtl/async_ops_pkg.sv
// Shared definitions for async handshake operator nodes: op codes,
// op/input-count validity and FIFO pointer sizing.
package async_ops_pkg;

    typedef enum logic [3:0] {
        OP_REG,
        OP_IN,
        OP_OUT,
        OP_ADDI,
        OP_SUBI,
        OP_MULI,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_MIN,
        OP_MAX,
        OP_BAD
    } op_e;

    // One extra MSB over the address width tells full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        ptr_width = $clog2(depth) + 1;
    endfunction

    function automatic bit op_valid(input op_e op, input int unsigned n);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_MIN, OP_MAX: op_valid = (n >= 1) && (n <= 3);
            OP_BAD:                                 op_valid = 1'b0;
            default:                                op_valid = (n == 1);
        endcase
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        is_pow2 = (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/buffered_op_alu.sv
// Combinational operator core: applies the configured op to up to three
// unsigned operands, truncating the result to data_width.
module buffered_op_alu
    import async_ops_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter op_e         op         = OP_REG,
    parameter int          immediate  = 0,
    parameter int unsigned input_size = 1
) (
    input  logic [data_width*input_size-1:0] operands,
    output logic [data_width-1:0]            result_c
);

    localparam logic [data_width-1:0] imm = data_width'(immediate);

    logic [data_width-1:0] opnd [3];
    logic [data_width-1:0] acc;

    // Absent inputs read as zero; the fold below only visits present ones.
    for (genvar i = 0; i < 3; i++) begin : g_opnd
        if (i < input_size) begin : g_used
            assign opnd[i] = operands[i*data_width +: data_width];
        end else begin : g_zero
            assign opnd[i] = '0;
        end
    end

    always_comb begin
        acc = opnd[0];
        case (op)
            OP_ADDI: acc = opnd[0] + imm;
            OP_SUBI: acc = opnd[0] - imm;
            OP_MULI: acc = opnd[0] * imm;
            default: begin
                for (int i = 1; i < 3; i++) begin
                    if (i < input_size) begin
                        case (op)
                            OP_ADD:  acc = acc + opnd[i];
                            OP_SUB:  acc = acc - opnd[i];
                            OP_MUL:  acc = acc * opnd[i];
                            OP_MIN:  if (opnd[i] < acc) acc = opnd[i];
                            OP_MAX:  if (opnd[i] > acc) acc = opnd[i];
                            default: ;
                        endcase
                    end
                end
            end
        endcase
        result_c = acc;
    end

endmodule

// File: rtl/buffered_async_operator.sv
// Dataflow operator node: gathers operands over req/ack, computes into a
// FIFO, and forks each result to every consumer independently.
module buffered_async_operator
    import async_ops_pkg::*;
#(
    parameter int unsigned data_width  = 32,
    parameter string       op          = "reg",
    parameter int          immediate   = 0,
    parameter int unsigned input_size  = 1,
    parameter int unsigned output_size = 1,
    parameter int unsigned depth       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [input_size-1:0]             req_l,
    input  logic [input_size-1:0]             ack_l,
    input  logic [data_width*input_size-1:0]  din,
    input  logic [output_size-1:0]            req_r,
    output logic [output_size-1:0]            ack_r,
    output logic [data_width*output_size-1:0] dout,
    output logic [31:0]                       fire_count,
    output logic [$clog2(depth):0]            occupancy
);

    localparam int unsigned ptr_w  = ptr_width(depth);
    localparam int unsigned addr_w = ptr_w - 1;
    localparam op_e op_sel =
        (op == "reg")  ? OP_REG  : (op == "in")   ? OP_IN   : (op == "out")  ? OP_OUT  :
        (op == "addi") ? OP_ADDI : (op == "subi") ? OP_SUBI : (op == "muli") ? OP_MULI :
        (op == "add")  ? OP_ADD  : (op == "sub")  ? OP_SUB  : (op == "mul")  ? OP_MUL  :
        (op == "min")  ? OP_MIN  : (op == "max")  ? OP_MAX  : OP_BAD;

    if (op_sel == OP_BAD) begin : g_bad_op
        $error("buffered_async_operator: unknown op '%s'", op);
    end
    if (op_sel != OP_BAD && !op_valid(op_sel, input_size)) begin : g_bad_inputs
        $error("buffered_async_operator: op '%s' cannot take input_size %0d", op, input_size);
    end
    if (!is_pow2(depth)) begin : g_bad_depth
        $error("buffered_async_operator: depth %0d is not a power of two >= 2", depth);
    end
    if (output_size < 1) begin : g_bad_outputs
        $error("buffered_async_operator: output_size must be at least 1");
    end

    logic [input_size-1:0]            has;
    logic [data_width*input_size-1:0] operands;
    logic [data_width-1:0]            fifo [depth];
    logic [data_width-1:0]            result;
    logic [ptr_w-1:0]                 wr_ptr;
    logic [ptr_w-1:0]                 wr_nxt;
    logic [ptr_w-1:0]                 rd_ptr [output_size];
    logic [ptr_w-1:0]                 rd_nxt [output_size];
    logic [output_size-1:0]           pop;
    logic [ptr_w-1:0]                 occ_nxt;
    logic                             full;
    logic                             fire;

    // occupancy always mirrors the current pointers, so full is pre-edge state.
    assign full = (occupancy == ptr_w'(depth));
    assign fire = (&has) && !full;

    buffered_op_alu #(
        .data_width (data_width),
        .op         (op_sel),
        .immediate  (immediate),
        .input_size (input_size)
    ) u_alu (
        .operands (operands),
        .result_c (result)
    );

    always_comb begin
        wr_nxt  = wr_ptr + ptr_w'(fire);
        occ_nxt = '0;
        for (int j = 0; j < output_size; j++) begin
            pop[j]    = req_r[j] && (rd_ptr[j] != wr_ptr) && !ack_r[j];
            rd_nxt[j] = rd_ptr[j] + ptr_w'(pop[j]);
            if ((wr_nxt - rd_nxt[j]) > occ_nxt) begin
                occ_nxt = wr_nxt - rd_nxt[j];
            end
        end
    end

    // Operand handshake: request when empty, capture on the first ack only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            has   <= '0;
            req_l <= '0;
        end else begin
            for (int i = 0; i < input_size; i++) begin
                if (ack_l[i] && !has[i]) begin
                    has[i]   <= 1'b1;
                    req_l[i] <= 1'b0;
                end else begin
                    if (fire) has[i] <= 1'b0;
                    if (!has[i] && !req_l[i] && !ack_l[i]) req_l[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < input_size; i++) begin
            if (ack_l[i] && !has[i]) begin
                operands[i*data_width +: data_width] <= din[i*data_width +: data_width];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) fifo[wr_ptr[addr_w-1:0]] <= result;
    end

    // Pointer bookkeeping and per-consumer result delivery.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            occupancy  <= '0;
            fire_count <= '0;
            ack_r      <= '0;
            dout       <= '0;
            for (int j = 0; j < output_size; j++) rd_ptr[j] <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            occupancy <= occ_nxt;
            if (fire) fire_count <= fire_count + 32'd1;
            for (int j = 0; j < output_size; j++) begin
                rd_ptr[j] <= rd_nxt[j];
                ack_r[j]  <= pop[j];
                if (pop[j]) dout[j*data_width +: data_width] <= fifo[rd_ptr[j][addr_w-1:0]];
            end
        end
    end

endmodule
